// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M issue/writeback controller.
package muldiv_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } issue_state_e;

endpackage

// File: rtl/muldiv_issue_ctrl.sv
// EX-stage issue/writeback controller for the RV32M multiply/divide unit.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no op in flight; accepts an M-op from EX
// S_ISSUE | md_req high until the unit reports ready
// S_WAIT  | unit busy; watchdog running; flush marks the op killed
// S_WB    | result held on the writeback port until granted
module muldiv_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [6:0]            ex_opcode,
  input  logic [2:0]            ex_funct3,
  input  logic [6:0]            ex_funct7,
  input  logic [4:0]            ex_rd,
  input  logic [DATA_WIDTH-1:0] ex_rs1_val,
  input  logic [DATA_WIDTH-1:0] ex_rs2_val,
  input  logic                  flush,
  output logic                  ex_stall,
  output logic                  md_req,
  output logic [2:0]            md_funct3,
  output logic                  md_funct7_bit5,
  output logic [DATA_WIDTH-1:0] md_operand_a,
  output logic [DATA_WIDTH-1:0] md_operand_b,
  input  logic                  md_ready,
  input  logic                  md_valid,
  input  logic [DATA_WIDTH-1:0] md_result,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  wb_ready,
  output logic                  timeout_err,
  output logic [31:0]           perf_mop_count,
  output logic [31:0]           perf_stall_count
);

  localparam int WDOG_W = 8;

  issue_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [4:0]            rd_q, rd_d;
  logic                  killed_q, killed_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic [31:0]           mop_cnt_q, mop_cnt_d, stall_cnt_q, stall_cnt_d;
  logic                  is_m_op, done, kill_now;

  assign is_m_op = ex_valid & (ex_opcode == OPCODE_OP) & (ex_funct7 == FUNCT7_MULDIV);

  // Next-state, handshake outputs, watchdog and counters.
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    wb_data_d   = wb_data_q;
    killed_d    = killed_q;
    wdog_d      = wdog_q;
    md_req      = 1'b0;
    wb_valid    = 1'b0;
    timeout_err = 1'b0;
    done        = 1'b0;
    // A flush in the same cycle as md_valid kills the result as well.
    kill_now    = killed_q | flush;

    case (state_q)
      S_IDLE: begin
        killed_d = 1'b0;
        if (is_m_op && !flush) begin
          op_a_d   = ex_rs1_val;
          op_b_d   = ex_rs2_val;
          funct3_d = ex_funct3;
          rd_d     = ex_rd;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        md_req = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else if (md_ready) begin
          wdog_d  = WDOG_W'(TIMEOUT_CYCLES - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        killed_d = kill_now;
        if (md_valid) begin
          killed_d = 1'b0;
          if (kill_now || rd_q == 5'd0) begin
            done    = ~kill_now;
            state_d = S_IDLE;
          end else begin
            wb_data_d = md_result;
            state_d   = S_WB;
          end
        end else if (wdog_q == '0) begin
          timeout_err = 1'b1;
          killed_d    = 1'b0;
          state_d     = S_IDLE;
        end else begin
          wdog_d = wdog_q - 1'b1;
        end
      end
      S_WB: begin
        // Never present a result the pipeline is discarding this cycle.
        wb_valid = ~flush;
        if (flush) begin
          state_d = S_IDLE;
        end else if (wb_ready) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ex_stall    = rst_n & is_m_op & ~flush & ~done;
    mop_cnt_d   = mop_cnt_q + {31'd0, done};
    stall_cnt_d = stall_cnt_q + {31'd0, ex_stall};
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      funct3_q    <= '0;
      rd_q        <= '0;
      wb_data_q   <= '0;
      killed_q    <= 1'b0;
      wdog_q      <= '0;
      mop_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      wb_data_q   <= wb_data_d;
      killed_q    <= killed_d;
      wdog_q      <= wdog_d;
      mop_cnt_q   <= mop_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign md_funct3        = funct3_q;
  assign md_funct7_bit5   = 1'b0;
  assign md_operand_a     = op_a_q;
  assign md_operand_b     = op_b_q;
  assign wb_rd            = rd_q;
  assign wb_data          = wb_data_q;
  assign perf_mop_count   = mop_cnt_q;
  assign perf_stall_count = stall_cnt_q;

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- Execute-stage issue/writeback controller for the RV32M multiply/divide unit.
- Decodes M-extension R-type instructions presented in EX and stalls the pipeline while the operation is in flight.
- Drives the unit's req/ready/valid handshake and holds its operands and funct3 stable until completion.
- Returns the result to the register-file writeback port, handles pipeline flush mid-operation, and keeps a watchdog and performance counters.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before the watchdog aborts; legal range 40..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  valid instruction in EX
- ex_opcode  in  7  instr[6:0]
- ex_funct3  in  3  instr[14:12]
- ex_funct7  in  7  instr[31:25]
- ex_rd  in  5  destination register
- ex_rs1_val  in  DATA_WIDTH  forwarded rs1 value
- ex_rs2_val  in  DATA_WIDTH  forwarded rs2 value
- flush  in  1  kill the EX instruction and anything in flight
- ex_stall  out  1  hold EX and upstream stages
- md_req  out  1  request to the mul/div unit
- md_funct3  out  3  operation to the unit
- md_funct7_bit5  out  1  constant 0
- md_operand_a  out  DATA_WIDTH  latched rs1
- md_operand_b  out  DATA_WIDTH  latched rs2
- md_ready  in  1  unit idle; req is accepted when md_req and md_ready are both high
- md_valid  in  1  one-cycle result strobe
- md_result  in  DATA_WIDTH  unit result, valid while md_valid is high
- wb_valid  out  1  writeback request
- wb_rd  out  5  writeback destination
- wb_data  out  DATA_WIDTH  writeback value
- wb_ready  in  1  register-file port granted
- timeout_err  out  1  one-cycle pulse on watchdog abort
- perf_mop_count  out  32  completed M-ops
- perf_stall_count  out  32  cycles with ex_stall high

Behaviour:
- is_m_op = ex_valid & (ex_opcode == 7'b0110011) & (ex_funct7 == 7'b0000001).
- Reset (asynchronous): state IDLE. All outputs and the killed flag are 0. Latched operands, funct3, rd, wb_data and both counters are 0.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE: if is_m_op and !flush, latch rs1, rs2, funct3 and rd; go to ISSUE.
- ISSUE: md_req = 1.
  - flush → IDLE, no request issued.
  - md_ready → WAIT.
  - Otherwise stay in ISSUE.
- WAIT: md_req = 0. Watchdog counts cycles; flush sets the killed flag.
  - On md_valid with killed, or with rd == 0: → IDLE, result discarded.
  - On md_valid otherwise: capture md_result into wb_data → WB.
  - Watchdog reaches TIMEOUT_CYCLES with no md_valid: pulse timeout_err, clear killed, → IDLE, no writeback. The EX instruction is then re-accepted unless flushed.
- WB: wb_valid = 1, holding wb_rd and wb_data.
  - wb_ready → IDLE.
  - flush → IDLE with wb_valid dropped. flush wins over wb_ready in the same cycle.
- md_operand_a, md_operand_b and md_funct3 come from the latches and must stay stable from ISSUE until leaving WAIT. The unit samples them during setup and reads operand_a for divide-by-zero remainder.
- done = (WB & wb_ready & !flush) | (WAIT & md_valid & !killed & rd == 0).
- ex_stall = is_m_op & !flush & !done. The EX instruction advances on the same edge on which it completes.
- A new M-op arriving while a killed op drains keeps ex_stall high and is accepted once back in IDLE.
- Latency for an accepted op, with acceptance at edge E0:
  - md_req high in cycle 1.
  - Multiply: md_valid in cycle 3, wb_valid in cycle 4.
  - Divide-by-zero: md_valid in cycle 2.
- perf_mop_count increments on done. perf_stall_count increments every cycle ex_stall is high. Both wrap modulo 2^32.
- md_req is never asserted outside ISSUE. md_valid arriving outside WAIT is ignored.

Decomposition:
- Shared package muldiv_pkg holds:
  - OPCODE_OP = 7'b0110011 and FUNCT7_MULDIV = 7'b0000001.
  - The eight funct3 localparams (MUL..REMU).
  - The issue state enum.
- Flat single module; no sub-module is warranted.

Test Plan:
- MUL with rs1 = 7, rs2 = 6, rd = 5, wb_ready held high → md_req in cycle 1; wb_valid in cycle 4 with wb_rd = 5, wb_data = 42; ex_stall high in cycles 0–3 and low in cycle 4; perf_mop_count = 1.
- DIVU with rs1 = 100, rs2 = 0 → md_operand_a stays 100 through md_valid; wb_data = 0xFFFFFFFF. REMU with the same operands → wb_data = 100.
- DIV with rs1 = -20, rs2 = 3, and flush asserted 5 cycles into WAIT → ex_stall drops immediately; no wb_valid; an immediately following MULHU with 0xFFFFFFFF × 2 is accepted only after md_valid and writes back 1.
- MULH with rs1 = -2, rs2 = 3, rd = 0 → no wb_valid; ex_stall released in the md_valid cycle.
- wb_ready held low for 3 cycles with a MUL result pending → wb_valid, wb_rd and wb_data stay stable and ex_stall stays high until the wb_ready cycle.
- md_valid never returned → timeout_err pulses after 64 WAIT cycles and the controller returns to IDLE. Separately, rst_n asserted while in WAIT → all outputs read 0 immediately.
